// File: rtl/raster_seq_pkg.sv
// Shared types for the raster sequencer: FSM state encoding and the
// packed triangle record carried through the queue.
package raster_seq_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SETUP,
    S_READY,
    S_ISSUE,
    S_DRAW,
    S_FRAME,
    S_FWAIT,
    S_FIN
  } state_t;

  // x1 occupies the most significant bits of the 96-bit upstream word.
  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] x3;
    logic [COORD_W-1:0] y3;
  } triangle_t;

endpackage

// File: rtl/tri_fifo.sv
// Circular triangle queue with first-word-fall-through read. A push into a
// full queue is refused even if a pop happens in the same cycle.
module tri_fifo
  import raster_seq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  triangle_t din,
  output triangle_t dout,
  output logic      full,
  output logic      empty
);

  triangle_t              mem_q [DEPTH];
  logic [LOG_DEPTH-1:0]   wr_ptr_q;
  logic [LOG_DEPTH-1:0]   rd_ptr_q;
  logic [LOG_DEPTH:0]     count_q;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count_q == (LOG_DEPTH + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (LOG_DEPTH + 1)'(1);
        2'b01:   count_q <= count_q - (LOG_DEPTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/raster_sequencer.sv
// Frame sequencer in front of the Rasteriser: queues triangles, then issues
// opcode_received / data_ready / frame_ready / finished as one-cycle pulses.
module raster_sequencer
  import raster_seq_pkg::*;
#(
  parameter int QUEUE_DEPTH     = 4,
  parameter int LOG_QUEUE_DEPTH = 2,
  parameter int SETUP_WAIT      = 5,
  parameter int FINISH_WAIT     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tri_valid,
  input  logic [6*COORD_W-1:0] tri_data,
  output logic                 tri_ready,
  input  logic                 frame_end,
  input  logic                 rast_next_triangle,
  output logic                 opcode_received,
  output logic                 data_ready,
  output logic                 frame_ready,
  output logic                 finished,
  output logic [COORD_W-1:0]   x1,
  output logic [COORD_W-1:0]   y1,
  output logic [COORD_W-1:0]   x2,
  output logic [COORD_W-1:0]   y2,
  output logic [COORD_W-1:0]   x3,
  output logic [COORD_W-1:0]   y3,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          tri_count
);

  state_t        state_q;
  logic [15:0]   wait_q;
  logic          end_pending_q;
  logic          end_pending_d;
  logic          opcode_q, data_ready_q, frame_ready_q, finished_q;
  logic [15:0]   tri_count_q;
  triangle_t     coord_q;
  triangle_t     fifo_dout;
  logic          fifo_full, fifo_empty;
  logic          take_tri;

  tri_fifo #(
    .DEPTH     (QUEUE_DEPTH),
    .LOG_DEPTH (LOG_QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tri_valid),
    .pop   (take_tri),
    .din   (tri_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The pop shares the edge that enters ISSUE, so coordinates and
  // data_ready appear together.
  assign take_tri = !fifo_empty &&
                    ((state_q == S_READY) || (state_q == S_DRAW && rast_next_triangle));

  // A frame_end coinciding with the FRAME-state clear belongs to the next frame.
  assign end_pending_d = frame_end ? 1'b1 : (state_q == S_FRAME) ? 1'b0 : end_pending_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      end_pending_q <= 1'b0;
      opcode_q      <= 1'b0;
      data_ready_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      finished_q    <= 1'b0;
      tri_count_q   <= '0;
      coord_q       <= '0;
    end else begin
      end_pending_q <= end_pending_d;
      opcode_q      <= 1'b0;
      data_ready_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      finished_q    <= 1'b0;
      if (take_tri) begin
        state_q      <= S_ISSUE;
        data_ready_q <= 1'b1;
        coord_q      <= fifo_dout;
        if (tri_count_q != 16'hFFFF) tri_count_q <= tri_count_q + 16'd1;
      end else begin
        case (state_q)
          S_IDLE: if (!fifo_empty || end_pending_q) begin
            state_q     <= S_START;
            opcode_q    <= 1'b1;
            tri_count_q <= '0;
          end
          S_START: begin
            state_q <= S_SETUP;
            wait_q  <= '0;
          end
          S_SETUP: if (wait_q == 16'(SETUP_WAIT - 1)) state_q <= S_READY;
                   else wait_q <= wait_q + 16'd1;
          S_READY: if (end_pending_q) begin
            state_q       <= S_FRAME;
            frame_ready_q <= 1'b1;
          end
          S_ISSUE: state_q <= S_DRAW;
          S_DRAW:  if (rast_next_triangle) state_q <= S_READY;
          S_FRAME: begin
            state_q <= S_FWAIT;
            wait_q  <= '0;
          end
          S_FWAIT: if (wait_q == 16'(FINISH_WAIT - 1)) begin
            state_q    <= S_FIN;
            finished_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
          S_FIN:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tri_ready       = !fifo_full;
  assign opcode_received = opcode_q;
  assign data_ready      = data_ready_q;
  assign frame_ready     = frame_ready_q;
  assign finished        = finished_q;
  assign frame_done      = finished_q;
  assign busy            = (state_q != S_IDLE);
  assign tri_count       = tri_count_q;
  assign x1 = coord_q.x1;
  assign y1 = coord_q.y1;
  assign x2 = coord_q.x2;
  assign y2 = coord_q.y2;
  assign x3 = coord_q.x3;
  assign y3 = coord_q.y3;

endmodule

// File: tb/tb_raster_sequencer.sv
// Directed bench for raster_sequencer: checks pulses, latencies, queue
// backpressure, empty frames, async reset and back-to-back frame_end.
module tb_raster_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tri_valid = 1'b0;
  logic [95:0] tri_data = '0;
  logic        tri_ready;
  logic        frame_end = 1'b0;
  logic        rast_next_triangle = 1'b0;
  logic        opcode_received, data_ready, frame_ready, finished;
  logic [15:0] x1, y1, x2, y2, x3, y3;
  logic        busy, frame_done;
  logic [15:0] tri_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  raster_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .tri_valid          (tri_valid),
    .tri_data           (tri_data),
    .tri_ready          (tri_ready),
    .frame_end          (frame_end),
    .rast_next_triangle (rast_next_triangle),
    .opcode_received    (opcode_received),
    .data_ready         (data_ready),
    .frame_ready        (frame_ready),
    .finished           (finished),
    .x1 (x1), .y1 (y1), .x2 (x2), .y2 (y2), .x3 (x3), .y3 (y3),
    .busy               (busy),
    .frame_done         (frame_done),
    .tri_count          (tri_count)
  );

  function automatic logic [95:0] mk_tri(input logic [15:0] a, b, c, d, e, f);
    return {a, b, c, d, e, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int k);
    case (k)
      0:       return opcode_received;
      1:       return data_ready;
      2:       return frame_ready;
      default: return finished;
    endcase
  endfunction

  // Bounded wait; returns in the cycle the chosen handshake is high.
  task automatic wait_sig(input int k, input int max, input string tag);
    int c = 0;
    while (!sig(k) && c < max) begin
      tick();
      c++;
    end
    chk(tag, {31'd0, sig(k)}, 32'd1);
  endtask

  // Handshake pulses must never overlap.
  always @(negedge clk) begin
    if (reset && (32'(opcode_received) + 32'(data_ready) + 32'(frame_ready) + 32'(finished)) > 1) begin
      n_tests++;
      n_fail++;
      $error("FAIL onehot: observed %b%b%b%b expected at most one",
             opcode_received, data_ready, frame_ready, finished);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dr_seen;

    // Reset state
    tick(); tick();
    chk("rst_ready", {31'd0, tri_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hs", {28'd0, opcode_received, data_ready, frame_ready, finished}, 32'd0);
    chk("rst_cnt", {16'd0, tri_count}, 32'd0);
    chk("rst_x1", {16'd0, x1}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: single triangle frame
    tri_valid = 1'b1; tri_data = mk_tri(20, 10, 30, 10, 20, 20); frame_end = 1'b1;
    tick();
    tri_valid = 1'b0; frame_end = 1'b0;
    tick();
    chk("t1_opcode", {31'd0, opcode_received}, 32'd1);
    dr_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); dr_seen |= data_ready; end
    chk("t1_dr_early", {31'd0, dr_seen}, 32'd0);
    tick();
    chk("t1_dr", {31'd0, data_ready}, 32'd1);
    chk("t1_coords", {x1, y1}, {16'd20, 16'd10});
    chk("t1_coords2", {x2, y2}, {16'd30, 16'd10});
    chk("t1_coords3", {16'd0, x3}, 32'd20);
    chk("t1_y3", {16'd0, y3}, 32'd20);
    tick();
    chk("t1_dr_pulse", {31'd0, data_ready}, 32'd0);
    rast_next_triangle = 1'b1;
    tick();
    rast_next_triangle = 1'b0;
    tick();
    chk("t1_frame_ready", {31'd0, frame_ready}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_fin_early", {31'd0, finished}, 32'd0);
    tick();
    chk("t1_finished", {31'd0, finished}, 32'd1);
    chk("t1_frame_done", {31'd0, frame_done}, 32'd1);
    chk("t1_count", {16'd0, tri_count}, 32'd1);
    tick();
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: two triangles, back-to-back issue
    tri_valid = 1'b1; tri_data = mk_tri(1, 2, 3, 4, 5, 6);
    tick();
    tri_data = mk_tri(7, 8, 25, 9, 10, 11); frame_end = 1'b1;
    tick();
    tri_valid = 1'b0; frame_end = 1'b0;
    wait_sig(0, 10, "t2_opcode_wait");
    wait_sig(1, 12, "t2_dr_wait");
    chk("t2_first_x2", {16'd0, x2}, 32'd3);
    tick();
    rast_next_triangle = 1'b1;
    tick();
    rast_next_triangle = 1'b0;
    chk("t2_dr_next", {31'd0, data_ready}, 32'd1);
    chk("t2_x2", {16'd0, x2}, 32'd25);
    chk("t2_count", {16'd0, tri_count}, 32'd2);
    tick();
    rast_next_triangle = 1'b1;
    tick();
    rast_next_triangle = 1'b0;
    wait_sig(3, 20, "t2_fin_wait");
    chk("t2_count_end", {16'd0, tri_count}, 32'd2);
    tick();

    // 3: backpressure while drawing
    tri_valid = 1'b1; tri_data = mk_tri(1, 0, 0, 0, 0, 0);
    tick();
    tri_valid = 1'b0;
    wait_sig(1, 12, "t3_dr_wait");
    tick();
    for (int i = 0; i < 4; i++) begin
      tri_valid = 1'b1; tri_data = mk_tri(16'(i + 2), 0, 0, 0, 0, 0);
      tick();
    end
    chk("t3_full", {31'd0, tri_ready}, 32'd0);
    tri_data = mk_tri(6, 0, 0, 0, 0, 0);
    tick();
    chk("t3_held", {31'd0, tri_ready}, 32'd0);
    rast_next_triangle = 1'b1;
    tick();
    rast_next_triangle = 1'b0;
    chk("t3_pop_dr", {31'd0, data_ready}, 32'd1);
    chk("t3_pop_x1", {16'd0, x1}, 32'd2);
    chk("t3_ready_after_pop", {31'd0, tri_ready}, 32'd1);
    tick();
    tri_valid = 1'b0;
    chk("t3_full_again", {31'd0, tri_ready}, 32'd0);
    for (int k = 3; k <= 6; k++) begin
      rast_next_triangle = 1'b1;
      tick();
      rast_next_triangle = 1'b0;
      chk($sformatf("t3_order_x1_%0d", k), {15'd0, data_ready, x1}, {15'd0, 1'b1, 16'(k)});
      tick();
    end
    frame_end = 1'b1; rast_next_triangle = 1'b1;
    tick();
    frame_end = 1'b0; rast_next_triangle = 1'b0;
    wait_sig(3, 20, "t3_fin_wait");
    chk("t3_count", {16'd0, tri_count}, 32'd6);
    tick();

    // 4: empty frame, then a new frame from a push
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    chk("t4_opcode", {31'd0, opcode_received}, 32'd1);
    chk("t4_count0", {16'd0, tri_count}, 32'd0);
    dr_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin tick(); dr_seen |= data_ready; end
    chk("t4_frame_ready", {31'd0, frame_ready}, 32'd1);
    chk("t4_no_dr", {31'd0, dr_seen}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_finished", {31'd0, finished}, 32'd1);
    chk("t4_count", {16'd0, tri_count}, 32'd0);
    tick();
    chk("t4_idle", {31'd0, busy}, 32'd0);
    tri_valid = 1'b1; tri_data = mk_tri(9, 9, 9, 9, 9, 9);
    tick();
    tri_valid = 1'b0;
    tick();
    chk("t4_new_opcode", {31'd0, opcode_received}, 32'd1);

    // 5: asynchronous reset while drawing with two queued
    wait_sig(1, 12, "t5_dr_wait");
    tick();
    tri_valid = 1'b1; tri_data = mk_tri(1, 1, 1, 1, 1, 1);
    tick();
    tri_data = mk_tri(2, 2, 2, 2, 2, 2);
    tick();
    tri_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_ready", {31'd0, tri_ready}, 32'd1);
    chk("t5_coords", {x1, y3}, 32'd0);
    chk("t5_count", {16'd0, tri_count}, 32'd0);
    tick();
    reset = 1'b1;
    dr_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); dr_seen |= opcode_received | busy; end
    chk("t5_quiet", {31'd0, dr_seen}, 32'd0);

    // 6: frame_end during FRAME opens a second empty frame
    tri_valid = 1'b1; tri_data = mk_tri(4, 4, 4, 4, 4, 4); frame_end = 1'b1;
    tick();
    tri_valid = 1'b0; frame_end = 1'b0;
    wait_sig(1, 12, "t6_dr_wait");
    tick();
    rast_next_triangle = 1'b1;
    tick();
    rast_next_triangle = 1'b0;
    wait_sig(2, 5, "t6_frame_wait");
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    wait_sig(3, 10, "t6_fin_wait");
    chk("t6_count", {16'd0, tri_count}, 32'd1);
    tick();
    chk("t6_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("t6_second_opcode", {31'd0, opcode_received}, 32'd1);
    dr_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin tick(); dr_seen |= data_ready; end
    chk("t6_second_frame", {31'd0, frame_ready}, 32'd1);
    chk("t6_second_no_dr", {31'd0, dr_seen}, 32'd0);
    wait_sig(3, 10, "t6_second_fin");
    chk("t6_second_count", {16'd0, tri_count}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_final_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
